mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 system clock; rst input 1 asynchronous active-low reset.
REQ-002 SHALL have IF-side ports: if_req in 1 fetch request; if_addr in 32 fetch byte address; if_done out 1 fetch complete pulse; if_data out 32 fetched word, little-endian.
REQ-003 SHALL have MEM-side ports: mem_req in 1 load/store request; mem_we in 1 1=store; mem_addr in 32 byte address; mem_len in 2 bytes-1 (0=1B, 1=2B, 3=4B, 2 illegal); mem_wdata in 32 store data, LSB first; mem_done out 1 complete pulse; mem_rdata out 32 load data, zero-extended.
REQ-004 SHALL have RAM ports: ram_addr out 32 byte address; ram_dout out 8 write byte; ram_din in 8 read byte, valid one cycle after its address; ram_wr out 1 write enable.
REQ-005 SHALL have stall ports: stallreq_from_if out 1 and stallreq_from_mem out 1, both feeding the pipeline stall controller.

Function
REQ-006 SHALL implement states IDLE, IF_RD, MEM_RD, MEM_WR, DONE; requests are sampled only in IDLE.
REQ-007 In IDLE, mem_req=1 SHALL win over if_req=1 at the same edge; the IF request waits, no preemption of an active transaction.
REQ-008 On acceptance SHALL latch address, length (IF always 4B), we and wdata; clear byte counter cnt; at the same edge drive ram_addr=address.
REQ-009 ram_addr, ram_dout and ram_wr SHALL be registered outputs.
REQ-010 Read of N bytes, accept edge E0: ram_addr=A+k from edge Ek, k=0..N-1; byte k captured from ram_din at edge E(k+2) into bits [8k+7:8k]; edge E(N+1) enters DONE.
REQ-011 Write of N bytes: ram_wr=1 with ram_dout=wdata[8k+7:8k] and ram_addr=A+k during the cycle after Ek, k=0..N-1; edge EN enters DONE with ram_wr=0.
REQ-012 Address increment SHALL be modulo 2^32 (0xFFFFFFFF+1 = 0x00000000).
REQ-013 In DONE the owning done output SHALL be high for exactly one cycle with data valid; next state IDLE unconditionally, so a request still asserted in the DONE cycle is not re-accepted.
REQ-014 if_data / mem_rdata SHALL hold their value until the next completed read of the same port; unread upper bytes SHALL be 0.
REQ-015 stallreq_from_if SHALL equal if_req AND NOT if_done; stallreq_from_mem SHALL equal mem_req AND NOT mem_done (combinational).
REQ-016 Requester dropping req mid-transaction SHALL NOT abort it; the transaction completes and the done pulse is issued.
REQ-017 mem_len=2 SHALL be treated as 4 bytes.
REQ-018 ram_wr SHALL be 0 in every state except MEM_WR.

Reset
REQ-019 rst=0 SHALL immediately, without waiting for clk, force state IDLE, cnt=0, ram_wr=0, ram_addr=0, ram_dout=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0.
REQ-020 Reset asserted mid-transaction SHALL abort it with no done pulse; after release the first rising edge with a request accepts it.

Verification
REQ-021 IF fetch at 0x100, RAM bytes 13,05,00,00 -> ram_addr 0x100..0x103 on E0..E3, if_done high one cycle after E5, if_data=0x00000513, stallreq_from_if=1 until then.
REQ-022 Simultaneous if_req and mem_req (load 1B at 0x20, byte 0xAB) -> mem first: mem_done after E2 with mem_rdata=0x000000AB; IF accepted in the following IDLE cycle.
REQ-023 Store 2B 0x1234 at 0x30 -> ram_wr=1 for exactly 2 cycles: (0x30,0x34) then (0x31,0x12); mem_done in the cycle after E2.
REQ-024 Load 4B at 0xFFFFFFFE -> ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-025 rst asserted during the second write byte -> ram_wr drops within the same cycle, no mem_done; a new request after release starts at cnt=0.
REQ-026 if_req held high through DONE -> exactly one transaction and one if_done pulse; a second fetch starts only from the IDLE cycle after DONE.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and load/store
// requests onto a single 8-bit synchronous RAM port.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic        ram_wr,
  output logic        stallreq_from_if,
  output logic        stallreq_from_mem
);

  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  nbytes;
  logic [2:0]  mem_nbytes;
  logic        owner_if;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [31:0] rbuf_nxt;
  logic [1:0]  rd_idx;
  logic [1:0]  wr_idx;
  logic        rd_last;
  logic        wr_last;

  // mem_len encodes bytes-1; the unused code 2 is widened to a full word
  always_comb begin
    case (mem_len)
      2'd0:    mem_nbytes = 3'd1;
      2'd1:    mem_nbytes = 3'd2;
      default: mem_nbytes = 3'd4;
    endcase
  end

  // cnt counts edges since acceptance; the RAM answers two edges after an
  // address is issued, so byte k lands when cnt == k+1
  assign rd_idx  = cnt[1:0] - 2'd1;
  assign wr_idx  = cnt[1:0] + 2'd1;
  assign rd_last = (cnt == nbytes);
  assign wr_last = ((cnt + 3'd1) == nbytes);

  always_comb begin
    rbuf_nxt = rbuf;
    rbuf_nxt[{rd_idx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_req)     state_nxt = mem_we ? MEM_WR : MEM_RD;
        else if (if_req) state_nxt = IF_RD;
      end
      IF_RD, MEM_RD: if (rd_last) state_nxt = DONE;
      MEM_WR:        if (wr_last) state_nxt = DONE;
      DONE:          state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_done           = (state == DONE) &&  owner_if;
    mem_done          = (state == DONE) && !owner_if;
    stallreq_from_if  = if_req  && !if_done;
    stallreq_from_mem = mem_req && !mem_done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 3'd0;
      nbytes    <= 3'd0;
      owner_if  <= 1'b0;
      wdata     <= 32'd0;
      rbuf      <= 32'd0;
      ram_addr  <= 32'd0;
      ram_dout  <= 8'd0;
      ram_wr    <= 1'b0;
      if_data   <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      ram_wr <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= 3'd0;
          rbuf <= 32'd0;
          if (mem_req) begin
            owner_if <= 1'b0;
            nbytes   <= mem_nbytes;
            wdata    <= mem_wdata;
            ram_addr <= mem_addr;
            ram_dout <= mem_wdata[7:0];
            ram_wr   <= mem_we;
          end else if (if_req) begin
            owner_if <= 1'b1;
            nbytes   <= 3'd4;
            ram_addr <= if_addr;
          end
        end
        IF_RD, MEM_RD: begin
          cnt <= cnt + 3'd1;
          if (cnt != 3'd0) rbuf <= rbuf_nxt;
          if ((cnt + 3'd1) < nbytes) ram_addr <= ram_addr + 32'd1;
          // publish only on completion so the port holds its previous word meanwhile
          if (rd_last) begin
            if (owner_if) if_data   <= rbuf_nxt;
            else          mem_rdata <= rbuf_nxt;
          end
        end
        MEM_WR: begin
          cnt <= cnt + 3'd1;
          if (!wr_last) begin
            ram_addr <= ram_addr + 32'd1;
            ram_dout <= wdata[{wr_idx, 3'b000} +: 8];
            ram_wr   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
